// File: rtl/fract_scheduler.sv
// fract_scheduler: render sequencer for the fractal iteration core.
//
// Sweeps every pixel of a frame in raster order, hands each pixel to the core with a
// frame-stable center, waits for the 1-bit result and writes it to the frame buffer.
// The sweep restarts at pixel 0 when a frame completes or when the pan registers move.
//
// Ports:
//   clk, rst            system clock and synchronous active-high reset
//   enable              render enable; low parks the sequencer after the current pixel
//   centerx, centery    live pan values from the register file
//   core_start          one-cycle start pulse to the core
//   core_px, core_py    pixel coordinates for the core
//   core_cx, core_cy    center latched at the start of the frame
//   core_done           core result strobe
//   core_pixel          core result, valid with core_done
//   write               frame-buffer write strobe
//   write_pixel         frame-buffer write data
//   write_addr          frame-buffer write address (py*H_RES+px)
//   busy                high whenever the sequencer is not idle
//   frame_done          one-cycle pulse when a complete frame has been written
//   frame_count         completed-frame counter, wraps at 256
module fract_scheduler #(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 9,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned COORD_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [COORD_W-1:0] centerx,
    input  logic [COORD_W-1:0] centery,
    output logic               core_start,
    output logic [X_W-1:0]     core_px,
    output logic [Y_W-1:0]     core_py,
    output logic [COORD_W-1:0] core_cx,
    output logic [COORD_W-1:0] core_cy,
    input  logic               core_done,
    input  logic               core_pixel,
    output logic               write,
    output logic               write_pixel,
    output logic [ADDR_W-1:0]  write_addr,
    output logic               busy,
    output logic               frame_done,
    output logic [7:0]         frame_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StIssue,
        StWait,
        StWrite
    } state_e;

    localparam logic [X_W-1:0] LastX = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] LastY = Y_W'(V_RES - 1);

    state_e               state_q;
    logic                 restart_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 start_q;
    logic [X_W-1:0]       px_q;
    logic [Y_W-1:0]       py_q;
    logic [COORD_W-1:0]   cx_q;
    logic [COORD_W-1:0]   cy_q;
    logic                 write_q;
    logic                 wpix_q;
    logic [ADDR_W-1:0]    waddr_q;
    logic                 busy_q;
    logic                 frame_done_q;
    logic [7:0]           frame_count_q;

    logic center_moved;
    logic last_px;

    assign center_moved = (centerx != cx_q) || (centery != cy_q);
    assign last_px      = (px_q == LastX) && (py_q == LastY);

    // All outputs are registers: each transition also loads the outputs that the
    // destination state presents, so core_start/write/busy line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            restart_q     <= 1'b0;
            addr_q        <= '0;
            start_q       <= 1'b0;
            px_q          <= '0;
            py_q          <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            write_q       <= 1'b0;
            wpix_q        <= 1'b0;
            waddr_q       <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            start_q      <= 1'b0;
            write_q      <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q <= StLatch;
                        busy_q  <= 1'b1;
                    end
                end
                StLatch: begin
                    // Center is sampled here directly, so a change now is not a restart.
                    cx_q      <= centerx;
                    cy_q      <= centery;
                    px_q      <= '0;
                    py_q      <= '0;
                    addr_q    <= '0;
                    restart_q <= 1'b0;
                    start_q   <= 1'b1;
                    state_q   <= StIssue;
                end
                StIssue: begin
                    if (center_moved) restart_q <= 1'b1;
                    state_q <= StWait;
                end
                StWait: begin
                    if (center_moved) restart_q <= 1'b1;
                    if (core_done) begin
                        wpix_q  <= core_pixel;
                        waddr_q <= addr_q;
                        write_q <= 1'b1;
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    // A move seen during this very cycle counts as a restart too.
                    if (restart_q || center_moved) begin
                        state_q <= StLatch;
                    end else if (!enable) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (last_px) begin
                        frame_done_q  <= 1'b1;
                        frame_count_q <= frame_count_q + 8'd1;
                        state_q       <= StLatch;
                    end else begin
                        if (px_q == LastX) begin
                            px_q <= '0;
                            py_q <= py_q + 1'b1;
                        end else begin
                            px_q <= px_q + 1'b1;
                        end
                        addr_q  <= addr_q + 1'b1;
                        start_q <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign core_start  = start_q;
    assign core_px     = px_q;
    assign core_py     = py_q;
    assign core_cx     = cx_q;
    assign core_cy     = cy_q;
    assign write       = write_q;
    assign write_pixel = wpix_q;
    assign write_addr  = waddr_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fract_scheduler.sv
// Self-checking bench for fract_scheduler on a 4x3 frame. The driver plays the core,
// predicts each write from a pixel-index model and queues it; the monitor pops and
// compares whenever the DUT writes.
module tb_fract_scheduler;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int N  = H * V;
    localparam int XW = 2;
    localparam int YW = 2;
    localparam int AW = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [CW-1:0] centerx = '0;
    logic [CW-1:0] centery = '0;
    logic          core_done = 1'b0;
    logic          core_pixel = 1'b0;
    logic          core_start;
    logic [XW-1:0] core_px;
    logic [YW-1:0] core_py;
    logic [CW-1:0] core_cx;
    logic [CW-1:0] core_cy;
    logic          write;
    logic          write_pixel;
    logic [AW-1:0] write_addr;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_count;

    fract_scheduler #(
        .H_RES  (H),
        .V_RES  (V),
        .X_W    (XW),
        .Y_W    (YW),
        .ADDR_W (AW),
        .COORD_W(CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .centerx    (centerx),
        .centery    (centery),
        .core_start (core_start),
        .core_px    (core_px),
        .core_py    (core_py),
        .core_cx    (core_cx),
        .core_cy    (core_cy),
        .core_done  (core_done),
        .core_pixel (core_pixel),
        .write      (write),
        .write_pixel(write_pixel),
        .write_addr (write_addr),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        bit data;
        bit last;
        int fcw;
        int fca;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            idx = 0;
    int            fc = 0;
    int            frames_model = 0;
    logic [CW-1:0] mcx = '0;
    logic [CW-1:0] mcy = '0;
    int            prev_start = 0;
    int            prev_lat = 0;
    bit            prev_plain = 0;
    bit            dead = 0;
    bit            fd_pend = 0;
    int            fd_fc = 0;
    int            fd_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_core_start", core_start, 0);
        chk("rst_write", write, 0);
        chk("rst_write_pixel", write_pixel, 0);
        chk("rst_write_addr", write_addr, 0);
        chk("rst_core_px", core_px, 0);
        chk("rst_core_py", core_py, 0);
        chk("rst_core_cx", core_cx, 0);
        chk("rst_core_cy", core_cy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_count", frame_count, 0);
    endtask

    // pert: 0 none, 1 pan move during WAIT, 2 enable drop during WAIT, 3 reset during WAIT
    task automatic do_pixel(input int lat, input int pert, input bit pxdata);
        int   w;
        bit   d;
        bit   restart;
        bit   lastp;
        exp_t e;
        w = 0;
        while (core_start !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (core_start !== 1'b1) begin
            chk("start_timeout", core_start, 1);
            dead = 1;
            return;
        end
        chk("start_px", core_px, idx % H);
        chk("start_py", core_py, idx / H);
        chk("start_cx", core_cx, mcx);
        chk("start_cy", core_cy, mcy);
        if (prev_plain) chk("start_gap", cyc - prev_start, prev_lat + 2);
        prev_start = cyc;
        prev_lat   = lat;
        d = pxdata ? (((idx % H) % 2) != 0) : 1'($urandom);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i == 1) begin
                if (pert == 1) begin
                    centerx = centerx + 32'h0001_0000;
                    if ($urandom % 2 == 0) centery = $urandom;
                end else if (pert == 2) begin
                    enable = 1'b0;
                end else if (pert == 3) begin
                    rst = 1'b1;
                    @(negedge clk);
                    chk_reset();
                    rst       = 1'b0;
                    core_done = 1'b1;  // stale result must not produce a write
                    @(negedge clk);
                    @(negedge clk);
                    core_done  = 1'b0;
                    idx        = 0;
                    fc         = 0;
                    mcx        = centerx;
                    mcy        = centery;
                    prev_plain = 0;
                    return;
                end
            end
        end
        core_done  = 1'b1;
        core_pixel = d;
        restart = (centerx != mcx) || (centery != mcy);
        lastp   = !restart && enable && (idx == N - 1);
        e.addr = idx;
        e.data = d;
        e.last = lastp;
        e.fcw  = fc;
        e.fca  = (fc + 1) % 256;
        q.push_back(e);
        @(negedge clk);
        core_done  = 1'b0;
        core_pixel = 1'($urandom);
        prev_plain = 0;
        if (restart) begin
            idx = 0;
            mcx = centerx;
            mcy = centery;
        end else if (!enable) begin
            idx = 0;
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_start", core_start, 0);
            repeat (3) begin
                core_done = 1'($urandom);
                @(negedge clk);
            end
            core_done = 1'b0;
            chk("idle_hold", {busy, core_start}, 0);
            enable = 1'b1;
        end else if (lastp) begin
            idx = 0;
            fc  = (fc + 1) % 256;
            frames_model++;
        end else begin
            idx++;
            prev_plain = 1;
        end
    endtask

    // Monitor: compares every write and frame_done against the queued predictions.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            fd_pend = 0;
        end else begin
            if (fd_pend || frame_done) begin
                chk("frame_done", frame_done, fd_pend);
                if (fd_pend) chk("frame_count_inc", frame_count, fd_fc);
                fd_pend = 0;
            end
            if (frame_done) fd_seen++;
            if (write) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", write, 0);
                end else begin
                    e = q.pop_front();
                    chk("write_addr", write_addr, e.addr);
                    chk("write_pixel", write_pixel, e.data);
                    chk("write_frame_count", frame_count, e.fcw);
                    if (e.last) begin
                        fd_pend = 1;
                        fd_fc   = e.fca;
                    end
                end
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int fc0;
        int fd0;
        int f0;
        int guard;
        int r;
        int pert;
        repeat (3) @(negedge clk);
        chk_reset();
        rst    = 1'b0;
        enable = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (core_start !== 1'b1 && w < 10);
        chk("first_start_cycle", w, 2);

        // One full frame, minimum latency, data = px[0].
        repeat (N) if (!dead) do_pixel(1, 0, 1);
        if (!dead) do_pixel(1, 0, 1);
        chk("frame1_pulses", fd_seen, 1);
        chk("frame1_count", frame_count, 1);

        // Long core latency.
        repeat (4) if (!dead) do_pixel(5, 0, 0);

        // Pan move while pixel 5 is in flight.
        while (idx != 5 && !dead) do_pixel(1, 0, 0);
        fc0 = fc;
        if (!dead) do_pixel(3, 1, 0);
        if (!dead) do_pixel(1, 0, 0);
        chk("restart_frame_count", frame_count, fc0);

        // Enable drop while pixel 2 is in flight.
        while (idx != 2 && !dead) do_pixel(1, 0, 0);
        if (!dead) do_pixel(2, 2, 0);
        if (!dead) do_pixel(1, 0, 0);

        // Reset while pixel 7 is in flight.
        while (idx != 7 && !dead) do_pixel(1, 0, 0);
        if (!dead) do_pixel(2, 3, 0);
        if (!dead) do_pixel(1, 0, 0);

        // Random run through 256 frames so frame_count wraps back to zero.
        fd0   = fd_seen;
        f0    = frames_model;
        guard = 0;
        while (frames_model - f0 < 256 && !dead && guard < 6000) begin
            r    = $urandom % 400;
            pert = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            do_pixel($urandom_range(1, 3), pert, 0);
            guard++;
        end
        if (!dead) do_pixel(1, 0, 0);
        repeat (2) @(negedge clk);
        chk("wrap_frame_count", frame_count, fc);
        chk("wrap_is_zero", frame_count, 0);
        chk("wrap_pulses", fd_seen - fd0, 256);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
